pcd_ctrl_gen: RTL and testbench
===============================

Name: pcd_ctrl_gen

Overview:
PACODAG control-data generator. It sits at the generator end of the PACODAG link of an input buffer. It accepts control-data requests (SOP while RDY) and matching per-packet statistics (STAT_DV). For each request it emits one 2-word control frame with FrameLink-style handshake: sequence number, request timestamp and status.

Parameters:
DATA_WIDTH, 64, width of CTRL_DATA; must be >= 64 and a multiple of 8
REQ_DEPTH, 4, number of outstanding requests held; power of 2, >= 2

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
CTRL_SOP  in  1  control-data request from buffer
CTRL_RDY  out  1  generator can accept a request this cycle
CTRL_STAT  in  1  packet status for oldest request awaiting status
CTRL_STAT_DV  in  1  CTRL_STAT valid
CTRL_DATA  out  DATA_WIDTH  control frame data
CTRL_REM  out  log2(DATA_WIDTH/8)  index of last valid byte
CTRL_SRC_RDY_N  out  1  data valid, active low
CTRL_DST_RDY_N  in  1  sink ready, active low
CTRL_SOP_N  out  1  first word of frame, active low
CTRL_EOP_N  out  1  last word of frame, active low
ERR  out  1  sticky protocol error flag

Behaviour:
- Interface: one clock, CLK. RESET is synchronous and active-high. All outputs are registered except CTRL_RDY.
- Outputs during and after reset: CTRL_SRC_RDY_N=1, CTRL_SOP_N=1, CTRL_EOP_N=1, CTRL_DATA=0, CTRL_REM=0, ERR=0. CTRL_RDY=0 while RESET=1.
- Reset also clears both FIFOs, the sequence counter and the timestamp counter.
- Timestamp: free-running 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF->0.
- Sequence counter: 32-bit, +1 per accepted request, wraps.
- CTRL_RDY = !RESET && request FIFO not full. It is combinational from the registered count.
- Request accept:
  - A request is accepted when CTRL_SOP=1 && CTRL_RDY=1.
  - On accept, {timestamp, seq} is pushed to the request FIFO and seq is incremented.
  - CTRL_SOP with CTRL_RDY=0 is ignored: no push, no seq change.
- Status:
  - pending = accepted requests minus statuses received, range 0..REQ_DEPTH.
  - CTRL_STAT_DV with pending>0 pushes CTRL_STAT to the status FIFO.
  - CTRL_STAT_DV with pending=0 is dropped and sets ERR. ERR is cleared only by RESET.
  - A request accept and a STAT_DV in the same cycle are both processed; the STAT_DV check uses pending before the accept.
- Frame content:
  - Word0: [31:0]=seq, [63:32]=timestamp captured at accept; remaining bits 0. CTRL_SOP_N=0, CTRL_EOP_N=1, CTRL_REM=all ones.
  - Word1: [0]=status bit, all other bits 0. CTRL_SOP_N=1, CTRL_EOP_N=0, CTRL_REM=3.
- FSM states: IDLE, W0, W1.
  - IDLE -> W0 when both FIFOs are non-empty. On this transition both FIFOs pop and word0 registers onto the outputs.
  - W0 -> W1 on CTRL_DST_RDY_N=0.
  - W1 -> W0 when DST_RDY_N=0 and both FIFOs are non-empty: pop, no bubble between frames.
  - W1 -> IDLE when DST_RDY_N=0 and no further frame is ready.
  - In W0/W1 with DST_RDY_N=1, all outputs hold stable.
  - SRC_RDY_N=0 exactly in W0/W1.
- Latency: STAT_DV sampled at edge t, FSM idle -> word0 valid after edge t+2 (minimum).
- Request FIFO full and popping in the same cycle: CTRL_RDY stays 0 that cycle (it depends on the registered count) and returns to 1 the next cycle.
- Reset mid-frame: the frame is abandoned without EOP. The next cycle shows reset output values and seq restarts at 0.

Test Plan:
- Single request: reset, CTRL_SOP=1 at timestamp 10; STAT=1/STAT_DV at timestamp 13; DST_RDY_N=0 -> word0=0x0000000A_00000000 with SOP_N=0, then word1=0x1 with EOP_N=0 and REM=3. ERR=0.
- Backpressure: as above but DST_RDY_N=1 for 5 cycles while word0 is presented -> DATA, SOP_N and SRC_RDY_N=0 stable for all 5 cycles; word1 appears one cycle after DST_RDY_N=0.
- Full queue: 4 SOPs, no STAT -> CTRL_RDY=0 after the 4th accept. A 5th SOP is ignored. After STAT_DV and frame seq 0 completes, CTRL_RDY=1; the next SOP gets seq 4.
- Orphan status: STAT_DV with no request pending -> ERR=1 and stays 1; SRC_RDY_N stays 1. Later SOP+STAT still produces a normal frame with seq 0.
- Back-to-back: 2 requests, 2 statuses (0 then 1), DST_RDY_N=0 -> 4 consecutive valid words with no idle cycle: seq 0 status 0, then seq 1 status 1.
- Reset mid-frame: RESET=1 during W1 -> next cycle SRC_RDY_N=1 and CTRL_RDY=0. After release, a new request yields seq 0 and no stale frame is emitted.

Source files
------------

// File: rtl/pcd_ctrl_gen.sv
// PACODAG control-data generator: queues requests and packet statuses
// and emits one 2-word control frame per request.
module pcd_ctrl_gen #(
  parameter  int DATA_WIDTH = 64,
  parameter  int REQ_DEPTH  = 4,
  localparam int RW = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CTRL_SOP,
  output logic                  CTRL_RDY,
  input  logic                  CTRL_STAT,
  input  logic                  CTRL_STAT_DV,
  output logic [DATA_WIDTH-1:0] CTRL_DATA,
  output logic [RW-1:0]         CTRL_REM,
  output logic                  CTRL_SRC_RDY_N,
  input  logic                  CTRL_DST_RDY_N,
  output logic                  CTRL_SOP_N,
  output logic                  CTRL_EOP_N,
  output logic                  ERR
);
  localparam int AW = $clog2(REQ_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, W0, W1} state_t;
  state_t state, nxt;

  logic [63:0]          req_mem [REQ_DEPTH];
  logic [REQ_DEPTH-1:0] st_mem;
  logic [AW-1:0]        req_wp, req_rp, st_wp, st_rp;
  logic [CW-1:0]        req_cnt, st_cnt;
  logic [31:0]          ts, seq;
  logic                 avail, avail_q, acc, st_push, orphan;
  logic                 pop, cur_stat;

  assign CTRL_RDY = !RESET && (req_cnt != CW'(REQ_DEPTH));
  assign acc      = CTRL_SOP && CTRL_RDY;
  assign avail    = (req_cnt != '0) && (st_cnt != '0);
  // req_cnt - st_cnt counts requests still waiting for their status
  assign st_push  = CTRL_STAT_DV && (req_cnt > st_cnt);
  assign orphan   = CTRL_STAT_DV && !(req_cnt > st_cnt);

  always_comb begin
    nxt = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        if (avail && avail_q) begin
          nxt = W0;
          pop = 1'b1;
        end
      end
      W0: begin
        if (!CTRL_DST_RDY_N) nxt = W1;
      end
      W1: begin
        if (!CTRL_DST_RDY_N) begin
          if (avail) begin
            nxt = W0;
            pop = 1'b1;
          end else begin
            nxt = IDLE;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (acc) req_mem[req_wp] <= {ts, seq};
    if (st_push) st_mem[st_wp] <= CTRL_STAT;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= IDLE;
      req_wp         <= '0;
      req_rp         <= '0;
      st_wp          <= '0;
      st_rp          <= '0;
      req_cnt        <= '0;
      st_cnt         <= '0;
      ts             <= '0;
      seq            <= '0;
      avail_q        <= 1'b0;
      cur_stat       <= 1'b0;
      ERR            <= 1'b0;
      CTRL_DATA      <= '0;
      CTRL_REM       <= '0;
      CTRL_SRC_RDY_N <= 1'b1;
      CTRL_SOP_N     <= 1'b1;
      CTRL_EOP_N     <= 1'b1;
    end else begin
      state   <= nxt;
      ts      <= ts + 32'd1;
      avail_q <= avail;
      if (orphan) ERR <= 1'b1;
      if (acc) begin
        req_wp <= req_wp + AW'(1);
        seq    <= seq + 32'd1;
      end
      if (st_push) st_wp <= st_wp + AW'(1);
      if (pop) begin
        req_rp <= req_rp + AW'(1);
        st_rp  <= st_rp + AW'(1);
      end
      case ({acc, pop})
        2'b10:   req_cnt <= req_cnt + CW'(1);
        2'b01:   req_cnt <= req_cnt - CW'(1);
        default: req_cnt <= req_cnt;
      endcase
      case ({st_push, pop})
        2'b10:   st_cnt <= st_cnt + CW'(1);
        2'b01:   st_cnt <= st_cnt - CW'(1);
        default: st_cnt <= st_cnt;
      endcase
      // status is latched at pop since its slot may be refilled meanwhile
      if (pop) begin
        CTRL_DATA      <= DATA_WIDTH'(req_mem[req_rp]);
        CTRL_REM       <= '1;
        CTRL_SRC_RDY_N <= 1'b0;
        CTRL_SOP_N     <= 1'b0;
        CTRL_EOP_N     <= 1'b1;
        cur_stat       <= st_mem[st_rp];
      end else if (state == W0 && !CTRL_DST_RDY_N) begin
        CTRL_DATA  <= DATA_WIDTH'(cur_stat);
        CTRL_REM   <= RW'(3);
        CTRL_SOP_N <= 1'b1;
        CTRL_EOP_N <= 1'b0;
      end else if (state == W1 && !CTRL_DST_RDY_N) begin
        CTRL_DATA      <= '0;
        CTRL_REM       <= '0;
        CTRL_SRC_RDY_N <= 1'b1;
        CTRL_EOP_N     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pcd_ctrl_gen.sv
// Bench for pcd_ctrl_gen: directed scenarios with literal checks plus
// random traffic, all compared every cycle against a queue-based model.
module tb_pcd_ctrl_gen;
  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RESET, CTRL_SOP, CTRL_STAT, CTRL_STAT_DV, CTRL_DST_RDY_N;
  logic          CTRL_RDY, CTRL_SRC_RDY_N, CTRL_SOP_N, CTRL_EOP_N, ERR;
  logic [DW-1:0] CTRL_DATA;
  logic [2:0]    CTRL_REM;

  always #5 CLK = ~CLK;

  pcd_ctrl_gen #(.DATA_WIDTH(DW), .REQ_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .CTRL_SOP(CTRL_SOP), .CTRL_RDY(CTRL_RDY),
    .CTRL_STAT(CTRL_STAT), .CTRL_STAT_DV(CTRL_STAT_DV),
    .CTRL_DATA(CTRL_DATA), .CTRL_REM(CTRL_REM),
    .CTRL_SRC_RDY_N(CTRL_SRC_RDY_N), .CTRL_DST_RDY_N(CTRL_DST_RDY_N),
    .CTRL_SOP_N(CTRL_SOP_N), .CTRL_EOP_N(CTRL_EOP_N), .ERR(ERR)
  );

  int ncmp = 0;
  int nerr = 0;

  // model: queued requests/statuses, and which word (0 none, 1, 2) is shown
  logic [63:0] m_req[$];
  bit          m_st[$];
  int unsigned m_ts, m_seq;
  bit          m_err, m_stat, m_ready_prev;
  int          m_phase;
  logic [63:0] m_w0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic mreset();
    m_req.delete();
    m_st.delete();
    m_ts = 0;
    m_seq = 0;
    m_err = 0;
    m_stat = 0;
    m_ready_prev = 0;
    m_phase = 0;
    m_w0 = '0;
  endtask

  task automatic compare(input bit rst);
    chk("rdy", CTRL_RDY, !rst && m_req.size() < DEPTH);
    chk("err", ERR, m_err);
    chk("src_rdy_n", CTRL_SRC_RDY_N, m_phase == 0);
    chk("sop_n", CTRL_SOP_N, m_phase != 1);
    chk("eop_n", CTRL_EOP_N, m_phase != 2);
    if (m_phase == 1) begin
      chk("word0", CTRL_DATA, m_w0);
      chk("rem0", CTRL_REM, 7);
    end else if (m_phase == 2) begin
      chk("word1", CTRL_DATA, {63'd0, m_stat});
      chk("rem1", CTRL_REM, 3);
    end
  endtask

  // a frame starts from idle once both halves have been queued a full cycle
  task automatic step(input bit rst, input bit sop, input bit stat,
                      input bit dv, input bit dst);
    int pend;
    bit ready;
    bit room;
    if (rst) begin
      mreset();
      return;
    end
    pend  = m_req.size() - m_st.size();
    ready = m_req.size() > 0 && m_st.size() > 0;
    room  = m_req.size() < DEPTH;
    if (m_phase == 0) begin
      if (ready && m_ready_prev) begin
        m_w0 = m_req.pop_front();
        m_stat = m_st.pop_front();
        m_phase = 1;
      end
    end else if (!dst) begin
      if (m_phase == 1) m_phase = 2;
      else if (ready) begin
        m_w0 = m_req.pop_front();
        m_stat = m_st.pop_front();
        m_phase = 1;
      end else m_phase = 0;
    end
    m_ready_prev = ready;
    if (sop && room) begin
      m_req.push_back({m_ts, m_seq});
      m_seq++;
    end
    if (dv) begin
      if (pend > 0) m_st.push_back(stat);
      else m_err = 1;
    end
    m_ts++;
  endtask

  task automatic cyc(input bit rst, input bit sop, input bit stat,
                     input bit dv, input bit dst);
    @(negedge CLK);
    RESET = rst;
    CTRL_SOP = sop;
    CTRL_STAT = stat;
    CTRL_STAT_DV = dv;
    CTRL_DST_RDY_N = dst;
    #1;
    compare(rst);
    step(rst, sop, stat, dv, dst);
  endtask

  task automatic rst2();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
  endtask

  task automatic wait_valid(input bit dst, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, dst);
      n++;
      if (!CTRL_SRC_RDY_N) break;
    end
    chk("valid", CTRL_SRC_RDY_N, 0);
  endtask

  initial begin
    int n, cnt;
    logic [63:0] w;
    logic [31:0] last;
    RESET = 1;
    CTRL_SOP = 0;
    CTRL_STAT = 0;
    CTRL_STAT_DV = 0;
    CTRL_DST_RDY_N = 0;
    @(posedge CLK);
    mreset();

    // single request
    rst2();
    chk("rst_data", CTRL_DATA, 0);
    chk("rst_rem", CTRL_REM, 0);
    while (m_ts != 10) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    while (m_ts != 13) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    wait_valid(0, n);
    chk("latency", n, 3);
    chk("single_w0", CTRL_DATA, 64'h0000000A_00000000);
    cyc(0, 0, 0, 0, 0);
    chk("single_w1", CTRL_DATA, 1);
    chk("single_rem", CTRL_REM, 3);
    chk("single_eop", CTRL_EOP_N, 0);
    chk("single_err", ERR, 0);

    // backpressure
    rst2();
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    wait_valid(1, n);
    w = CTRL_DATA;
    chk("bp_w0", w, 64'h00000003_00000000);
    repeat (5) begin
      cyc(0, 0, 0, 0, 1);
      chk("bp_hold", CTRL_DATA, w);
      chk("bp_sop", CTRL_SOP_N, 0);
      chk("bp_src", CTRL_SRC_RDY_N, 0);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("bp_w1", CTRL_EOP_N, 0);

    // full queue
    rst2();
    repeat (4) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("full_rdy", CTRL_RDY, 0);
    cyc(0, 0, 1, 1, 0);
    wait_valid(0, n);
    chk("full_seq0", CTRL_DATA[31:0], 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("full_rdy_back", CTRL_RDY, 1);
    cyc(0, 1, 0, 0, 0);
    cnt = 0;
    last = '1;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 1, i < 4, 0);
      if (!CTRL_SRC_RDY_N && !CTRL_SOP_N) begin
        cnt++;
        last = CTRL_DATA[31:0];
      end
    end
    chk("full_frames", cnt, 4);
    chk("full_seq4", last, 4);

    // orphan status
    rst2();
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("orphan_err", ERR, 1);
    chk("orphan_src", CTRL_SRC_RDY_N, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    wait_valid(0, n);
    chk("orphan_seq", CTRL_DATA[31:0], 0);
    chk("orphan_sticky", ERR, 1);

    // back-to-back frames
    rst2();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    wait_valid(0, n);
    chk("b2b_w0a", CTRL_DATA, 64'h0);
    cyc(0, 0, 0, 0, 0);
    chk("b2b_w1a", CTRL_DATA, 0);
    chk("b2b_src1", CTRL_SRC_RDY_N, 0);
    cyc(0, 0, 0, 0, 0);
    chk("b2b_w0b", CTRL_DATA, 64'h00000001_00000001);
    chk("b2b_src2", CTRL_SRC_RDY_N, 0);
    cyc(0, 0, 0, 0, 0);
    chk("b2b_w1b", CTRL_DATA, 1);
    chk("b2b_src3", CTRL_SRC_RDY_N, 0);

    // reset mid-frame
    rst2();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    wait_valid(0, n);
    cyc(0, 0, 0, 0, 0);
    chk("mid_w1", CTRL_EOP_N, 0);
    cyc(1, 0, 0, 0, 0);
    chk("mid_rdy", CTRL_RDY, 0);
    cyc(0, 0, 0, 0, 0);
    chk("mid_src", CTRL_SRC_RDY_N, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    wait_valid(0, n);
    chk("mid_seq", CTRL_DATA[31:0], 0);

    // random traffic
    rst2();
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(299) == 0, $urandom_range(1) == 1,
          $urandom_range(1) == 1, $urandom_range(2) == 0,
          $urandom_range(3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end
endmodule
